matrix_bram_loader: RTL

//  Host-side writer that fills the weight and input BRAMs read by the NxN matrix-vector engine.

---
 rtl/matrix_bram_loader_pkg.sv | 10 +
 rtl/matrix_bram_loader_row_buffer.sv | 24 ++
 rtl/matrix_bram_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/matrix_bram_loader_pkg.sv
// matrix_bram_loader_pkg: shared FSM encoding, command selects and weight-word lane positions.
package matrix_bram_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_W_EVEN, S_W_ODD, S_X_LOAD, S_FIN} state_t;
    localparam logic CMD_SEL_WEIGHT = 1'b0;
    localparam logic CMD_SEL_INPUT  = 1'b1;
    localparam int LANE_R0_C0 = 0;
    localparam int LANE_R1_C0 = 1;
    localparam int LANE_R0_C1 = 2;
    localparam int LANE_R1_C1 = 3;
endpackage

// File: rtl/matrix_bram_loader_row_buffer.sv
// loader_row_buffer: N-entry element register file holding the even row of the current weight tile.
module loader_row_buffer #(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int CW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [CW-1:0]    i_col_w,
    input  logic [ACC_W-1:0] i_wdata,
    input  logic [CW-1:0]    i_col_r,
    output logic [ACC_W-1:0] o_rdata
);
    logic [ACC_W-1:0] r_mem [N];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_col_w] <= i_wdata;
        end
    end
    assign o_rdata = r_mem[i_col_r];
endmodule

// File: rtl/matrix_bram_loader.sv
// matrix_bram_loader: packs a row-major weight stream into 4-lane tiled BRAM words, or copies x[] to the input BRAM.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum output over the accepted elements of a load.
module matrix_bram_loader
    import matrix_bram_loader_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int N         = 4,
    parameter int N_MACS    = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic                        cmd_sel,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [ACC_W-1:0]            s_data,
    input  logic                        s_last,
    output logic                        wbram_we,
    output logic [$clog2(MEM_DEPTH)-1:0] wbram_addr,
    output logic [N_MACS*ACC_W-1:0]     wbram_din,
    output logic                        ibram_we,
    output logic [$clog2(MEM_DEPTH)-1:0] ibram_addr,
    output logic [ACC_W-1:0]            ibram_din,
    output logic                        busy,
    output logic                        done,
    output logic                        err
`ifdef LOADER_CHECKSUM_EN
    ,output logic [ACC_W-1:0]           checksum
`endif
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(N);

    state_t               r_state;
    logic [CW-1:0]        r_col;
    logic [CW-1:0]        r_tile;
    logic [AW-1:0]        r_wptr;
    logic [ACC_W-1:0]     r_hold0;
    logic [ACC_W-1:0]     r_hold1;
    logic [ACC_W-1:0]     w_buf;
    logic [N_MACS*ACC_W-1:0] w_word;
    logic                 w_fire;
    logic                 w_final;
    logic [CW-1:0]        w_col_nxt;

    assign s_ready   = r_state inside {S_W_EVEN, S_W_ODD, S_X_LOAD};
    assign w_fire    = s_valid & s_ready;
    assign w_col_nxt = (r_col == CW'(N - 1)) ? '0 : r_col + 1'b1;
    assign w_final   = (r_col == CW'(N - 1)) &&
                       (r_state == S_X_LOAD || (r_state == S_W_ODD && r_tile == CW'(N / 2 - 1)));

    loader_row_buffer #(.N(N), .ACC_W(ACC_W), .CW(CW)) u_row_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_fire && r_state == S_W_EVEN),
        .i_col_w (r_col),
        .i_wdata (s_data),
        .i_col_r (r_col),
        .o_rdata (w_buf)
    );

    // Odd-column beat completes the 2x2 block: buffer row 2t plus held row 2t+1 element
    always_comb begin
        w_word = '0;
        w_word[LANE_R0_C0*ACC_W +: ACC_W] = r_hold0;
        w_word[LANE_R1_C0*ACC_W +: ACC_W] = r_hold1;
        w_word[LANE_R0_C1*ACC_W +: ACC_W] = w_buf;
        w_word[LANE_R1_C1*ACC_W +: ACC_W] = s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_tile     <= '0;
            r_wptr     <= '0;
            r_hold0    <= '0;
            r_hold1    <= '0;
            wbram_we   <= 1'b0;
            wbram_addr <= '0;
            wbram_din  <= '0;
            ibram_we   <= 1'b0;
            ibram_addr <= '0;
            ibram_din  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wbram_we <= 1'b0;
            ibram_we <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_state <= (cmd_sel == CMD_SEL_WEIGHT) ? S_W_EVEN : S_X_LOAD;
                    r_col   <= '0;
                    r_tile  <= '0;
                    r_wptr  <= '0;
                    busy    <= 1'b1;
                    err     <= 1'b0;
                end
                S_W_EVEN: if (w_fire) begin
                    r_col <= w_col_nxt;
                    if (r_col == CW'(N - 1)) r_state <= S_W_ODD;
                end
                S_W_ODD: if (w_fire) begin
                    r_col <= w_col_nxt;
                    if (!r_col[0]) begin
                        r_hold0 <= w_buf;
                        r_hold1 <= s_data;
                    end else begin
                        wbram_we   <= 1'b1;
                        wbram_addr <= r_wptr;
                        wbram_din  <= w_word;
                        r_wptr     <= r_wptr + 1'b1;
                    end
                    if (r_col == CW'(N - 1)) begin
                        r_state <= S_W_EVEN;
                        r_tile  <= r_tile + 1'b1;
                    end
                end
                S_X_LOAD: if (w_fire) begin
                    r_col      <= w_col_nxt;
                    ibram_we   <= 1'b1;
                    ibram_addr <= AW'(r_col);
                    ibram_din  <= s_data;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Early or missing s_last ends/flags the load; later assignment overrides the state advance above
            if (w_fire && (s_last || w_final)) r_state <= S_FIN;
            if (w_fire && (s_last != w_final)) err <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [ACC_W-1:0] r_csum;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_csum <= '0;
        else if (r_state == S_IDLE && cmd_valid) r_csum <= '0;
        else if (w_fire) r_csum <= r_csum ^ s_data;
    end
    assign checksum = r_csum;
`endif
endmodule
